// File: rtl/multicycle_main_fsm_if.sv
// Control/datapath bundle between the multicycle main FSM and its datapath.
// The datapath (master) drives opcode and status; the controller (slave) drives strobes/selects.
interface multicycle_main_fsm_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       Op;
    logic             Zero;
    logic             mem_ready;
    logic             PCWrite;
    logic             AdrSrc;
    logic             IRWrite;
    logic             MemWrite;
    logic             RegWrite;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       ResultSrc;
    logic [1:0]       ImmSrc;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        output Op, Zero, mem_ready,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
        input  ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc,
        input  illegal, state, retired
    );

    modport slave (
        input  Op, Zero, mem_ready,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
        output ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc,
        output illegal, state, retired
    );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of a multicycle RISC-V core with memory wait states,
// sticky illegal-opcode trap and a retired-instruction counter.
module multicycle_main_fsm #(
    parameter bit EN_IALU = 1'b1,
    parameter bit EN_JAL  = 1'b1,
    parameter int CNT_W   = 32
) (
    input logic clk,
    input logic reset,
    multicycle_main_fsm_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        JAL      = 4'd8,
        ALUWB    = 4'd9,
        BEQ      = 4'd10,
        ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    // pc_fetch/ir_fetch/branch are enables that get qualified by mem_ready or Zero
    typedef struct packed {
        logic       adr;
        logic       mem_wr;
        logic       reg_wr;
        logic       pc_wr;
        logic       pc_fetch;
        logic       ir_fetch;
        logic       branch;
        logic [1:0] alu_a;
        logic [1:0] alu_b;
        logic [1:0] alu_op;
        logic [1:0] res;
    } ctrl_t;

    function automatic ctrl_t decode(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.alu_b = 2'b10; c.res = 2'b10;
                c.pc_fetch = 1'b1; c.ir_fetch = 1'b1;
            end
            DECODE:   begin c.alu_a = 2'b01; c.alu_b = 2'b01; end
            MEMADR:   begin c.alu_a = 2'b10; c.alu_b = 2'b01; end
            MEMREAD:  c.adr = 1'b1;
            MEMWB:    begin c.res = 2'b01; c.reg_wr = 1'b1; end
            MEMWRITE: begin c.adr = 1'b1; c.mem_wr = 1'b1; end
            EXECR:    begin c.alu_a = 2'b10; c.alu_op = 2'b10; end
            EXECI:    begin c.alu_a = 2'b10; c.alu_b = 2'b01; c.alu_op = 2'b10; end
            JAL:      begin c.alu_a = 2'b01; c.alu_b = 2'b10; c.pc_wr = 1'b1; end
            ALUWB:    c.reg_wr = 1'b1;
            BEQ:      begin c.alu_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_t           st;
    state_t           nxt;
    ctrl_t            ctrl_q;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;

    always_comb begin
        nxt = st;
        case (st)
            FETCH:   nxt = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R:         nxt = EXECR;
                    OP_I:         nxt = EN_IALU ? EXECI : ILLEGAL;
                    OP_JAL:       nxt = EN_JAL ? JAL : ILLEGAL;
                    OP_BEQ:       nxt = BEQ;
                    default:      nxt = ILLEGAL;
                endcase
            end
            MEMADR:   nxt = (bus.Op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  nxt = bus.mem_ready ? MEMWB : MEMREAD;
            MEMWB:    nxt = FETCH;
            MEMWRITE: nxt = bus.mem_ready ? FETCH : MEMWRITE;
            EXECR, EXECI, JAL: nxt = ALUWB;
            ALUWB, BEQ: nxt = FETCH;
            ILLEGAL:  nxt = ILLEGAL;
            default:  nxt = FETCH;
        endcase
    end

    // Moore outputs are registered alongside the state by decoding the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= FETCH;
            ctrl_q    <= decode(FETCH);
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            st        <= nxt;
            ctrl_q    <= decode(nxt);
            illegal_q <= illegal_q | (nxt == ILLEGAL);
            if (st != FETCH && nxt == FETCH)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Strobes carry same-cycle mem_ready/Zero qualification and are forced off while in reset
    assign bus.PCWrite   = ~reset & (ctrl_q.pc_wr | (ctrl_q.pc_fetch & bus.mem_ready)
                                     | (ctrl_q.branch & bus.Zero));
    assign bus.IRWrite   = ~reset & ctrl_q.ir_fetch & bus.mem_ready;
    assign bus.MemWrite  = ~reset & ctrl_q.mem_wr;
    assign bus.RegWrite  = ~reset & ctrl_q.reg_wr;
    assign bus.AdrSrc    = ctrl_q.adr;
    assign bus.ALUSrcA   = ctrl_q.alu_a;
    assign bus.ALUSrcB   = ctrl_q.alu_b;
    assign bus.ALUOp     = ctrl_q.alu_op;
    assign bus.ResultSrc = ctrl_q.res;
    assign bus.illegal   = illegal_q;
    assign bus.state     = st;
    assign bus.retired   = retired_q;

    always_comb begin
        case (bus.Op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BEQ:  bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = EN_JAL ? 2'b11 : 2'b00;
            default: bus.ImmSrc = 2'b00;
        endcase
    end
endmodule
